// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and latency helper for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of rising edges (accepting edge counted as the first) until out_valid on the normal path
    function automatic int latency(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step on magnitudes
module div_step #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH:0]   partial_nx,
    output logic             q_bit
);

    localparam int PW = WIDTH + 1;

    logic [WIDTH+1:0] shifted;

    // Shift in the next dividend bit, subtract the divisor only when it fits
    always_comb begin
        shifted    = {partial, bit_in};
        q_bit      = shifted >= {2'b00, divisor};
        partial_nx = PW'(q_bit ? shifted - {2'b00, divisor} : shifted);
    end

endmodule

// File: rtl/seq_div.sv
// seq_div: sequential restoring divider, signed/unsigned, valid/ready handshakes
module seq_div
    import div_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH:0]   partial, partial_nx;
    logic [WIDTH-1:0] dvd, dvs, q;
    logic             sq, sr, dz, q_bit;
    logic [CW-1:0]    cnt;
    logic             take, a_neg, b_neg, zero, ovf;

    assign take  = in_valid & in_ready;
    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign zero  = b == '0;
    assign ovf   = is_signed && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1;

    assign quotient    = q;
    assign remainder   = partial[WIDTH-1:0];
    assign div_by_zero = dz;

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial   (partial),
        .divisor   (dvs),
        .bit_in    (dvd[WIDTH-1]),
        .partial_nx(partial_nx),
        .q_bit     (q_bit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake outputs; special cases skip straight to DONE
    always_comb begin
        state_nx  = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        case (state)
            IDLE:    if (take) state_nx = (zero || ovf) ? DONE : CALC;
            CALC:    if (cnt == '0) state_nx = FIXUP;
            FIXUP:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch magnitudes on accept, iterate MSB first, then apply signs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial <= '0;
            dvd     <= '0;
            dvs     <= '0;
            q       <= '0;
            sq      <= 1'b0;
            sr      <= 1'b0;
            dz      <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    dvd     <= a_neg ? -a : a;
                    dvs     <= b_neg ? -b : b;
                    sq      <= a_neg ^ b_neg;
                    sr      <= a_neg;
                    cnt     <= CW'(WIDTH - 1);
                    dz      <= zero;
                    partial <= zero ? {1'b0, a} : '0;
                    q       <= zero ? '1 : ovf ? a : '0;
                end
                CALC: begin
                    partial <= partial_nx;
                    q       <= {q[WIDTH-2:0], q_bit};
                    dvd     <= dvd << 1;
                    cnt     <= cnt - 1'b1;
                end
                FIXUP: begin
                    q       <= sq ? -q : q;
                    partial <= {1'b0, sr ? -partial[WIDTH-1:0] : partial[WIDTH-1:0]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed and randomized checks of seq_div at WIDTH=24
module tb_seq_div;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         is_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int failures = 0;

    seq_div #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        a         = W'($urandom);
        b         = W'($urandom);
        is_signed = 1'($urandom);
    endtask

    // Present one operation; when align is set, drive from a falling edge first
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sg, input bit align);
        if (align) @(negedge clk);
        a         = av;
        b         = bv;
        is_signed = sg;
        in_valid  = 1'b1;
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    // Latency counts the accepting edge as edge 1
    task automatic wait_out(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edz, input int elat, input int hold);
        int lat;
        wait_out(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
            chk({tag, "_hold_q"}, 64'(quotient), 64'(eq));
        end
        chk({tag, "_q"}, 64'(quotient), 64'(eq));
        chk({tag, "_r"}, 64'(remainder), 64'(er));
        chk({tag, "_dz"}, {63'd0, div_by_zero}, {63'd0, edz});
        chk({tag, "_in_ready_done"}, {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        scramble();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_out_valid_drop"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_no_same_cycle_accept"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv, input logic sg,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz, input int elat,
                       input int hold);
        send(av, bv, sg, 1'b1);
        finish_op(tag, eq, er, edz, elat, hold);
    endtask

    // Reference built on the simulator's own / and % (truncating division)
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sg,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz, output int lat);
        longint sa, sb;
        dz  = bv == '0;
        lat = W + 2;
        if (dz) begin
            q   = '1;
            r   = av;
            lat = 1;
        end else if (sg) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            if (av == 24'h800000 && bv == 24'hFFFFFF) lat = 1;
        end else begin
            q = av / bv;
            r = av % bv;
        end
    endtask

    initial begin
        logic [W-1:0] eq, er, av, bv;
        logic         edz, sg;
        int           elat, seen;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        chk("rst_dz", {63'd0, div_by_zero}, 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send(24'd1000, 24'd7, 1'b0, 1'b0);
        finish_op("u1000_7", 24'd142, 24'd6, 1'b0, 26, 0);
        run("s_neg1000_7", 24'hFFFC18, 24'd7, 1'b1, 24'hFFFF72, 24'hFFFFFA, 1'b0, 26, 0);
        run("div0", 24'h123456, 24'd0, 1'b0, 24'hFFFFFF, 24'h123456, 1'b1, 1, 0);
        run("s_div0_neg", 24'hFFFFF0, 24'd0, 1'b1, 24'hFFFFFF, 24'hFFFFF0, 1'b1, 1, 0);
        run("s_min_neg1", 24'h800000, 24'hFFFFFF, 1'b1, 24'h800000, 24'd0, 1'b0, 1, 0);
        run("u_min_max", 24'h800000, 24'hFFFFFF, 1'b0, 24'd0, 24'h800000, 1'b0, 26, 0);
        run("s_7_neg2", 24'd7, 24'hFFFFFE, 1'b1, 24'hFFFFFD, 24'd1, 1'b0, 26, 0);
        run("s_neg7_neg2", 24'hFFFFF9, 24'hFFFFFE, 1'b1, 24'd3, 24'hFFFFFF, 1'b0, 26, 0);
        run("u_max_1", 24'hFFFFFF, 24'd1, 1'b0, 24'hFFFFFF, 24'd0, 1'b0, 26, 0);
        run("s_min_3", 24'h800000, 24'd3, 1'b1, 24'hD55556, 24'hFFFFFE, 1'b0, 26, 0);
        run("u_small_big", 24'd5, 24'd9, 1'b0, 24'd0, 24'd5, 1'b0, 26, 0);
        run("hold10", 24'd100, 24'd9, 1'b0, 24'd11, 24'd1, 1'b0, 26, 10);
        send(24'd5000, 24'd3, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_q", 64'(quotient), 64'd0);
        chk("midrst_r", 64'(remainder), 64'd0);
        chk("midrst_dz", {63'd0, div_by_zero}, 64'd0);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("midrst_abandoned", 64'(seen), 64'd0);
        run("after_rst", 24'd81, 24'd9, 1'b0, 24'd9, 24'd0, 1'b0, 26, 0);
        for (int i = 0; i < 24; i++) begin
            av = W'($urandom);
            bv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom) >> $urandom_range(0, 22);
            sg = 1'($urandom);
            if (i == 5) begin
                av = 24'h800000;
                bv = 24'hFFFFFF;
                sg = 1'b1;
            end
            model(av, bv, sg, eq, er, edz, elat);
            run($sformatf("rand%0d", i), av, bv, sg, eq, er, edz, elat, $urandom_range(0, 2));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter WIDTH, default 24, operand/result width; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operands and mode presented.
REQ-005 SHALL have port in_ready  output  1  high only in IDLE; transfer = in_valid & in_ready at a rising edge.
REQ-006 SHALL have port a  input  WIDTH  dividend.
REQ-007 SHALL have port b  input  WIDTH  divisor.
REQ-008 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port out_valid  output  1  result held stable until accepted.
REQ-010 SHALL have port out_ready  input  1  consumer accepts; transfer = out_valid & out_ready.
REQ-011 SHALL have port quotient  output  WIDTH  result quotient.
REQ-012 SHALL have port remainder  output  WIDTH  result remainder.
REQ-013 SHALL have port div_by_zero  output  1  flag for the current result, b == 0.

Function
REQ-014 SHALL implement states IDLE, CALC, FIXUP, DONE.
REQ-015 IDLE: in_ready=1; on input transfer, SHALL latch the operands and mode, then go to CALC, or to DONE for the special cases in REQ-019/020.
REQ-016 CALC SHALL hold an iteration counter counting WIDTH-1 down to 0.
REQ-017 CALC SHALL resolve one quotient bit per cycle, MSB first, using restoring division on operand magnitudes with a WIDTH+1-bit partial remainder.
REQ-018 CALC SHALL go to FIXUP after the count-0 cycle; FIXUP SHALL apply the signs, then go to DONE.
REQ-019 Signed mode sign rules SHALL be: quotient negative iff operand signs differ; remainder takes the dividend's sign; magnitudes computed as unsigned WIDTH bits, so a = most-negative is handled.
REQ-020 b==0 SHALL bypass CALC: quotient = all ones, remainder = a, div_by_zero=1, DONE one edge after acceptance.
REQ-021 Signed a = most-negative with b = -1 SHALL bypass CALC: quotient = a, remainder = 0, div_by_zero=0, DONE one edge after acceptance.
REQ-022 Normal latency: out_valid SHALL rise exactly WIDTH+2 rising edges after the accepting edge.
REQ-023 DONE: out_valid=1 and outputs SHALL stay constant while out_ready=0.
REQ-024 On output transfer the block SHALL return to IDLE; a new input SHALL NOT be accepted in that same cycle (in_ready=0 in DONE).
REQ-025 Inputs a, b, is_signed SHALL be ignored outside an input transfer.
REQ-026 Unsigned results SHALL satisfy a == quotient*b + remainder and remainder < b for b != 0.

Reset
REQ-027 Asserting rst_n low SHALL asynchronously force IDLE, in_ready=1, out_valid=0, and quotient, remainder, div_by_zero to 0.
REQ-028 Reset mid-CALC or in DONE SHALL abandon the operation with no result emitted.
REQ-029 After reset release, the first rising edge SHALL be able to accept an input.

Structure
REQ-030 A shared package div_pkg SHALL hold the state enum type and the latency constant function (WIDTH+2).
REQ-031 One combinational sub-module div_step SHALL perform one restoring step: partial, divisor, next dividend bit in; new partial and quotient bit out.
REQ-032 CALC SHALL instantiate div_step once.
REQ-033 Datapath registers SHALL be: partial (WIDTH+1), dividend shift (WIDTH), divisor magnitude (WIDTH), quotient (WIDTH), two sign bits, counter (clog2(WIDTH)).

Verification (WIDTH=24)
REQ-034 Unsigned a=1000, b=7 -> quotient=142, remainder=6, out_valid 26 edges after acceptance.
REQ-035 Signed a=-1000, b=7 -> quotient=-142 (0xFFFF72), remainder=-6 (0xFFFFFA).
REQ-036 a=0x123456, b=0 -> quotient=0xFFFFFF, remainder=0x123456, div_by_zero=1, latency 1.
REQ-037 Signed a=0x800000, b=0xFFFFFF -> quotient=0x800000, remainder=0, latency 1.
REQ-038 Hold out_ready=0 for 10 cycles in DONE, then pulse rst_n low mid-CALC of the next operation -> outputs stable while held; after reset out_valid=0 and in_ready=1.
REQ-039 Random back-to-back unsigned and signed operations against a reference model -> every result matches, with no dropped or duplicated transfers.
